// File: rtl/mon_host_link_if.sv
// Host-side bundle for the monitor serial link.
// Groups the packet handshake toward the CPU side: a transmit request
// channel (tx_data/tx_valid/tx_ready) and a receive result channel
// (rx_data/rx_valid/rx_err).
//   master : the packet user (drives tx_data/tx_valid, consumes rx results)
//   slave  : mon_host_link itself (drives tx_ready and the rx results)
interface mon_host_link_if #(
  parameter int DATA_W = 40
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, rx_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, rx_err
  );
endinterface

// File: rtl/mon_host_link.sv
// Host end of the monitor serial link.
// Serializes DATA_W-bit command packets onto to_mon and deserializes
// DATA_W-bit reply packets from from_mon, one bit per mon_clk cycle.
// Frame: start bit (0), DATA_W data bits MSB first, stop bit (1).
// Ports:
//   mon_clk  : link clock, all logic on the rising edge
//   reset_n  : synchronous active-low reset
//   host     : packet handshake bundle (slave side)
//   to_mon   : registered serial line to the device, idles high
//   from_mon : asynchronous serial line from the device, idles high
module mon_host_link #(
  parameter int DATA_W = 40,
  parameter int GAP    = 4,
  parameter int SYNC   = 2
) (
  input  logic            mon_clk,
  input  logic            reset_n,
  mon_host_link_if.slave  host,
  output logic            to_mon,
  input  logic            from_mon
);

  localparam logic [5:0] LAST_BIT = 6'(DATA_W - 1);
  localparam int         GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_STOP  = 3'd3,
    TX_GAP   = 3'd4
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_DATA    = 2'd1,
    RX_STOP    = 2'd2,
    RX_WAIT_HI = 2'd3
  } rx_state_t;

  tx_state_t         tx_state_r;
  logic [DATA_W-1:0] tx_shift_r;
  logic [5:0]        tx_cnt_r;
  logic [GAP_W-1:0]  gap_cnt_r;
  logic              to_mon_r;
  logic              tx_ready_r;

  logic [SYNC-1:0]   sync_r;
  logic              rxs_s;

  rx_state_t         rx_state_r;
  logic [DATA_W-1:0] rx_shift_r;
  logic [5:0]        rx_cnt_r;
  logic [DATA_W-1:0] rx_data_r;
  logic              rx_valid_r;
  logic              rx_err_r;

  // Transmit FSM: every output is registered for the state being entered,
  // so to_mon never glitches and tx_ready is low in every busy state.
  always_ff @(posedge mon_clk) begin
    if (!reset_n) begin
      tx_state_r <= TX_IDLE;
      tx_shift_r <= '0;
      tx_cnt_r   <= 6'd0;
      gap_cnt_r  <= '0;
      to_mon_r   <= 1'b1;
      tx_ready_r <= 1'b0;
    end else begin
      case (tx_state_r)
        TX_IDLE: begin
          to_mon_r <= 1'b1;
          // Accept uses the registered ready, so inputs seen while busy are ignored.
          if (host.tx_valid && tx_ready_r) begin
            tx_shift_r <= host.tx_data;
            tx_state_r <= TX_START;
            tx_ready_r <= 1'b0;
            to_mon_r   <= 1'b0;
          end else begin
            tx_ready_r <= 1'b1;
          end
        end
        TX_START: begin
          to_mon_r   <= tx_shift_r[DATA_W-1];
          tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
          tx_cnt_r   <= 6'd0;
          tx_state_r <= TX_DATA;
        end
        TX_DATA: begin
          if (tx_cnt_r == LAST_BIT) begin
            to_mon_r   <= 1'b1;
            tx_state_r <= TX_STOP;
          end else begin
            to_mon_r   <= tx_shift_r[DATA_W-1];
            tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
            tx_cnt_r   <= tx_cnt_r + 6'd1;
          end
        end
        TX_STOP: begin
          to_mon_r  <= 1'b1;
          gap_cnt_r <= '0;
          if (GAP == 0) begin
            tx_state_r <= TX_IDLE;
            tx_ready_r <= 1'b1;
          end else begin
            tx_state_r <= TX_GAP;
          end
        end
        TX_GAP: begin
          to_mon_r <= 1'b1;
          if (gap_cnt_r == GAP_LAST) begin
            tx_state_r <= TX_IDLE;
            tx_ready_r <= 1'b1;
          end else begin
            gap_cnt_r <= gap_cnt_r + 1'b1;
          end
        end
        default: begin
          tx_state_r <= TX_IDLE;
          to_mon_r   <= 1'b1;
          tx_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Synchronizer for the asynchronous from_mon line; resets to idle-high.
  always_ff @(posedge mon_clk) begin
    if (!reset_n) begin
      sync_r <= '1;
    end else begin
      sync_r <= {sync_r[SYNC-2:0], from_mon};
    end
  end

  assign rxs_s = sync_r[SYNC-1];

  // Receive FSM: the start cycle is detected in IDLE, data follows on the
  // next DATA_W cycles, and a low stop bit parks in WAIT_HI so a stuck-low
  // line reports exactly one error.
  always_ff @(posedge mon_clk) begin
    if (!reset_n) begin
      rx_state_r <= RX_IDLE;
      rx_shift_r <= '0;
      rx_cnt_r   <= 6'd0;
      rx_data_r  <= '0;
      rx_valid_r <= 1'b0;
      rx_err_r   <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      rx_err_r   <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          rx_cnt_r <= 6'd0;
          if (!rxs_s) begin
            rx_state_r <= RX_DATA;
          end else begin
            rx_state_r <= RX_IDLE;
          end
        end
        RX_DATA: begin
          rx_shift_r <= {rx_shift_r[DATA_W-2:0], rxs_s};
          if (rx_cnt_r == LAST_BIT) begin
            rx_state_r <= RX_STOP;
          end else begin
            rx_cnt_r <= rx_cnt_r + 6'd1;
          end
        end
        RX_STOP: begin
          if (rxs_s) begin
            rx_data_r  <= rx_shift_r;
            rx_valid_r <= 1'b1;
            rx_state_r <= RX_IDLE;
          end else begin
            rx_err_r   <= 1'b1;
            rx_state_r <= RX_WAIT_HI;
          end
        end
        RX_WAIT_HI: begin
          if (rxs_s) begin
            rx_state_r <= RX_IDLE;
          end else begin
            rx_state_r <= RX_WAIT_HI;
          end
        end
        default: begin
          rx_state_r <= RX_IDLE;
        end
      endcase
    end
  end

  assign to_mon        = to_mon_r;
  assign host.tx_ready = tx_ready_r;
  assign host.rx_data  = rx_data_r;
  assign host.rx_valid = rx_valid_r;
  assign host.rx_err   = rx_err_r;

endmodule
